// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a byte image (header N, then 4*N little-endian data bytes) into instruction memory.
// Define CHECKSUM_EN to require a trailing XOR-of-data byte before the core is released from reset.
module imem_program_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
`ifdef CHECKSUM_EN
        S_CHK    = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [1:0]        r_idx;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              w_fire;
    logic              w_hdr_bad;
    logic              w_last_word;
`ifdef CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    assign w_fire      = byte_valid & byte_ready;
    assign w_hdr_bad   = (byte_data == 8'd0) || ({24'd0, byte_data} > 32'(DEPTH));
    assign w_last_word = (r_word_cnt + CNT_W'(1)) == r_len;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_HEADER;
            S_HEADER: if (w_fire) w_next = w_hdr_bad ? S_ERR : S_DATA;
            S_DATA:   if (w_fire && r_idx == 2'd3) w_next = S_WRITE;
            S_WRITE: begin
                if (!w_last_word) w_next = S_DATA;
`ifdef CHECKSUM_EN
                else              w_next = S_CHK;
`else
                else              w_next = S_DONE;
`endif
            end
`ifdef CHECKSUM_EN
            S_CHK:    if (w_fire) w_next = (byte_data == r_xor) ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: if (start) w_next = S_HEADER;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_HEADER: byte_ready = 1'b1;
            S_DATA:   byte_ready = 1'b1;
`ifdef CHECKSUM_EN
            S_CHK:    byte_ready = 1'b1;
`endif
            S_WRITE:  imem_we    = 1'b1;
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERR:    error      = 1'b1;
            default:  ;
        endcase
    end

    // Bytes shift in from the top so after three bytes r_asm holds {b2, b1, b0}.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_idx        <= '0;
            r_asm        <= '0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            if (r_state == S_HEADER && w_fire) begin
                r_len      <= CNT_W'(byte_data);
                r_word_cnt <= '0;
                r_idx      <= '0;
            end
            if (r_state == S_DATA && w_fire) begin
                r_idx <= r_idx + 2'd1;
                r_asm <= {byte_data, r_asm[23:8]};
                if (r_idx == 2'd3) begin
                    r_imem_addr  <= ADDR_W'(r_word_cnt);
                    r_imem_wdata <= {byte_data, r_asm};
                end
            end
            if (r_state == S_WRITE) r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || (w_next == S_HEADER && r_state != S_HEADER)) r_xor <= '0;
        else if (r_state == S_DATA && w_fire)                     r_xor <= r_xor ^ byte_data;
    end
`endif
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a write scoreboard built from the byte image checks every cycle.
// Covers both builds; the CHECKSUM_EN sections add the trailer byte and the checksum cases.
`timescale 1ns/1ps
module tb_imem_program_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        time               t;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int  n_cmp  = 0;
    int  n_fail = 0;
    wr_t exp_q [$];

    imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge: a write happens exactly when the scoreboard says a word completed one edge earlier.
    always @(negedge clk) begin : compare
        logic exp_we;
        exp_we = (exp_q.size() > 0) && (exp_q[0].t == $time);
        check("imem_we", 32'(imem_we), 32'(exp_we));
        if (exp_we) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_q[0].addr));
            check("imem_wdata", imem_wdata, exp_q[0].data);
            check("byte_ready_in_write", 32'(byte_ready), 32'd0);
            void'(exp_q.pop_front());
        end
        check("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
        check("done_error_exclusive", 32'(done & error), 32'd0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, output time t_acc);
        bit got;
        got        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) got = 1'b1;
        end
        @(posedge clk);
        t_acc = $time;
        #1;
        byte_valid = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_accept_timeout: byte 0x%02h not accepted, byte_ready=%b expected 1", b, byte_ready);
        end
    endtask

    task automatic idle_cycle();
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Header, data and (in checksum builds, for a complete image) the trailer; expected writes are queued.
    task automatic send_image(input logic [7:0] n, input byte_q_t bytes, input bit toggle);
        time         t;
        logic [31:0] word;
        logic [7:0]  x;
        word = '0;
        x    = '0;
        send_byte(n, t);
        if (n == 8'd0 || int'(n) > DEPTH) return;
        if (toggle) idle_cycle();
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], t);
            word[8*(i%4) +: 8] = bytes[i];
            x = x ^ bytes[i];
            if (i % 4 == 3) exp_q.push_back('{t + 5, ADDR_W'(i / 4), word});
            if (toggle) idle_cycle();
        end
`ifdef CHECKSUM_EN
        if (bytes.size() == 4 * int'(n)) send_byte(x, t);
`endif
    endtask

    task automatic settle(input string tag, input logic exp_done, input logic exp_err);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        @(posedge clk);
        #1;
    endtask

    task automatic check_hold(input string tag, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        check({tag, "_addr_hold"}, 32'(imem_addr), addr);
        check({tag, "_wdata_hold"}, imem_wdata, data);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic probe_not_ready(input string tag);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    initial begin
        byte_q_t img;
        byte_q_t none;
        time     t;

        // Reset values
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("por");

        // Basic load with byte_valid held high
        pulse_start();
        img = '{8'h67, 8'h10, 8'h00, 8'h00, 8'h83, 8'h00, 8'h00, 8'h00};
        send_image(8'd2, img, 1'b0);
`ifdef CHECKSUM_EN
        @(negedge clk);
        check("basic_done_latency", 32'(done), 32'd1);
`else
        @(negedge clk);
        check("basic_done_in_write", 32'(done), 32'd0);
        @(negedge clk);
        check("basic_done_latency", 32'(done), 32'd1);
        check("basic_cpu_reset_latency", 32'(cpu_reset), 32'd0);
`endif
        @(posedge clk);
        #1;
        probe_not_ready("done_state");
        settle("basic", 1'b1, 1'b0);
        check_hold("basic", 32'd1, 32'h0000_0083);

        // Backpressure: valid toggles between bytes
        pulse_start();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_image(8'd1, img, 1'b1);
        settle("backpressure", 1'b1, 1'b0);
        check_hold("backpressure", 32'd0, 32'hDDCC_BBAA);

        // Header bounds
        pulse_start();
        send_image(8'd0, none, 1'b0);
        settle("hdr_zero", 1'b0, 1'b1);
        probe_not_ready("err_state");
        pulse_start();
        send_image(8'd33, none, 1'b0);
        settle("hdr_33", 1'b0, 1'b1);
        pulse_start();
        img.delete();
        for (int i = 0; i < 128; i++) img.push_back(8'((i * 7 + 3) & 8'hFF));
        send_image(8'd32, img, 1'b0);
        settle("hdr_32", 1'b1, 1'b0);
        check_hold("hdr_32", 32'd31, {img[127], img[126], img[125], img[124]});

        // Reset in the middle of word 1
        pulse_start();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_image(8'd2, img, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check_reset_values("midword");
        probe_not_ready("idle_state");
        pulse_start();
        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_image(8'd1, img, 1'b0);
        settle("fresh", 1'b1, 1'b0);
        check_hold("fresh", 32'd0, 32'h0000_0013);

        // Restart after done; start during DATA is ignored
        pulse_start();
        send_byte(8'd1, t);
        @(negedge clk);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_done_cleared", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b1;
        send_byte(8'h33, t);
        send_byte(8'h01, t);
        start = 1'b0;
        send_byte(8'h10, t);
        send_byte(8'h00, t);
        exp_q.push_back('{t + 5, ADDR_W'(0), 32'h0010_0133});
`ifdef CHECKSUM_EN
        send_byte(8'h22, t);
`endif
        settle("restart", 1'b1, 1'b0);
        check_hold("restart", 32'd0, 32'h0010_0133);

`ifdef CHECKSUM_EN
        // Trailer must equal the XOR of the data bytes
        pulse_start();
        send_byte(8'd1, t);
        send_byte(8'h01, t);
        send_byte(8'h02, t);
        send_byte(8'h04, t);
        send_byte(8'h08, t);
        exp_q.push_back('{t + 5, ADDR_W'(0), 32'h0804_0201});
        send_byte(8'h0F, t);
        settle("csum_good", 1'b1, 1'b0);
        pulse_start();
        send_byte(8'd1, t);
        send_byte(8'h01, t);
        send_byte(8'h02, t);
        send_byte(8'h04, t);
        send_byte(8'h08, t);
        exp_q.push_back('{t + 5, ADDR_W'(0), 32'h0804_0201});
        send_byte(8'h0E, t);
        settle("csum_bad", 1'b0, 1'b1);
`endif

        repeat (2) @(posedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
